arb_req_ctrl: RTL and testbench
===============================

Name: arb_req_ctrl

Overview:
Upstream request-management stage for the 3-way priority arbiter. It counts per-client request pulses, drives the arbiter's level `req[2:0]`, and consumes one pending request per granted cycle. After a channel's last request, it blanks that channel for the arbiter's grant latency, so lagging grants are not double-counted.

Parameters:
NREQ, 3, number of client channels; must match arbiter width.
DEPTH, 4, maximum pending requests per channel.
GNT_LAT, 5, arbiter request-to-grant latency in cycles; must equal arbiter DELAY.
STARVE_MAX, 16, cycles in REQ without a grant before the starve flag sets (optional feature only).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
push  input  NREQ  per-client request pulse; one pending request per cycle high
gnt  input  NREQ  grant from arbiter, onehot0
req  output  NREQ  request level to arbiter, registered
pend_cnt  output  NREQ*CNT_W  per-channel pending count, packed with channel 0 in the LSBs; CNT_W=$clog2(DEPTH+1)
full  output  NREQ  per-channel full indication, pend_cnt==DEPTH
ovf  output  NREQ  sticky: push dropped because the channel was full
gnt_err  output  NREQ  sticky: gnt seen in IDLE, or gnt seen in REQ with count 0
starve  output  NREQ  sticky starvation flag (STARVE_MON_EN only; else tied 0)

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: all counts 0, all channels IDLE, `req`=0, `ovf`/`gnt_err`/`starve`=0, blank and starve counters 0. Reset mid-operation discards all pending requests immediately.
- Each channel is an independent FSM with states IDLE, REQ and BLANK.
- Count update each cycle: `inc` = `push[i]` and (not full, or `dec` this cycle); `dec` = `gnt[i]` and state==REQ and cnt>0.
  - cnt_next = cnt + inc - dec.
  - Push while full with no dec: dropped, `ovf[i]` set.
  - Push and dec in the same cycle: count unchanged.
- IDLE: `req`=0.
  - Go to REQ when cnt_next>0, so `req` rises one cycle after the first push.
  - `gnt` in IDLE: ignored, `gnt_err[i]` set.
- REQ: `req`=1.
  - Each cycle with `gnt[i]`=1 consumes one request.
  - If cnt_next==0, go to BLANK and load blank_cnt=GNT_LAT-1. `req` falls in the same cycle the FSM enters BLANK.
  - `gnt[i]` with cnt==0 (unreachable by design): `gnt_err` set, no decrement.
- BLANK: `req`=0.
  - `gnt[i]` is ignored and not flagged.
  - Pushes are still accepted.
  - blank_cnt decrements every cycle. At 0, go to REQ if cnt_next>0, else IDLE.
  - GNT_LAT=0: skip BLANK entirely.
- No cross-channel interaction: priority belongs to the arbiter. `full`/`pend_cnt` are combinational from the registered count.

Optional Feature:
Macro: ARB_REQ_STARVE_MON_EN.
- Defined:
  - Per-channel wait counter, cleared on `gnt[i]` or when leaving REQ.
  - Increments each REQ cycle without a grant, saturating.
  - `starve[i]` set (sticky until reset) when the counter reaches STARVE_MAX.
- Undefined: no counters; `starve` tied to 0.

Decomposition:
- Package arb_pkg: NREQ default, `typedef enum logic [1:0] {IDLE, REQ, BLANK} ch_state_e`, CNT_W helper function.
- Sub-module arb_req_chan holds the FSM, counters and flags for one channel. It is instantiated NREQ times via generate; the top only packs and unpacks buses.

Test Plan:
1. Reset: `rst_n`=0 with `push`=3'b111 -> `req`=0, all counts 0. Release, then one `push`=3'b001 -> `req`=3'b001 one cycle later, `pend_cnt[0]`=1.
2. Single consume: ch0 cnt=1, `gnt`=3'b001 for 1 cycle -> `req[0]` falls. Further `gnt[0]` held 5 cycles -> cnt stays 0, `gnt_err[0]`=0. Returns to IDLE after 5 cycles.
3. Overflow: 5 pushes on ch1, no grants -> `pend_cnt[1]`=4, `full[1]`=1, `ovf[1]`=1. Then push and gnt in the same cycle -> cnt stays 4, no new drop.
4. Push during blank: ch2 drained, push in the 2nd BLANK cycle -> cnt=1, `req[2]` reasserts on blank expiry (GNT_LAT cycles after the fall).
5. Spurious grant: all IDLE, `gnt`=3'b010 -> `gnt_err`=3'b010, counts unchanged.
6. (STARVE_MON_EN) ch2 pending, arbiter grants only ch0 for 16 cycles -> `starve[2]`=1. With the macro undefined -> `starve`=0.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared types and helpers for the arbiter request-management stage.
//   NREQ_DEF   : default number of client channels
//   ch_state_e : per-channel FSM state (IDLE, REQ, BLANK)
//   cnt_w()    : width of a pending-request counter able to hold 0..depth
package arb_pkg;

   localparam int unsigned NREQ_DEF = 3;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      BLANK
   } ch_state_e;

   function automatic int unsigned cnt_w(input int unsigned depth);
      return (depth == 0) ? 1 : $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/arb_req_chan.sv
// arb_req_chan: request FSM, pending counter and status flags for one client.
// Optional macro ARB_REQ_STARVE_MON_EN adds a saturating wait counter and a
// sticky starvation flag; without it starve_o is tied low.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : request pulse from the client
//   gnt_i         : grant for this channel from the arbiter
//   req_o         : registered request level to the arbiter
//   cnt_o         : pending request count
//   full_o        : cnt_o == DEPTH
//   ovf_o         : sticky, a push was dropped while full
//   gnt_err_o     : sticky, grant seen in IDLE or in REQ with no pending request
//   starve_o      : sticky, waited STARVE_MAX cycles in REQ without a grant
module arb_req_chan
   import arb_pkg::*;
#(
`ifdef ARB_REQ_STARVE_MON_EN
   parameter int unsigned STARVE_MAX = 16,
`endif
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned GNT_LAT    = 5,
   parameter int unsigned CNT_W      = cnt_w(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             gnt_i,
   output logic             req_o,
   output logic [CNT_W-1:0] cnt_o,
   output logic             full_o,
   output logic             ovf_o,
   output logic             gnt_err_o,
   output logic             starve_o
);

   localparam int unsigned BLK_W = (GNT_LAT > 1) ? $clog2(GNT_LAT) : 1;
   localparam logic [BLK_W-1:0] BLK_LOAD = (GNT_LAT == 0) ? '0 : BLK_W'(GNT_LAT - 1);

   ch_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [BLK_W-1:0] blank_q, blank_d;
   logic             req_q, ovf_q, ovf_d, gnt_err_q, gnt_err_d;
   logic             full, inc, dec;

   always_comb begin
      full      = (cnt_q == CNT_W'(DEPTH));
      dec       = gnt_i && (state_q == REQ) && (cnt_q != '0);
      // a push into a full channel still lands when a grant frees a slot
      inc       = push_i && (!full || dec);
      cnt_d     = cnt_q + CNT_W'(inc) - CNT_W'(dec);
      ovf_d     = ovf_q | (push_i & full & ~dec);
      gnt_err_d = gnt_err_q | (gnt_i & ((state_q == IDLE) |
                                        ((state_q == REQ) & (cnt_q == '0))));
      state_d   = state_q;
      blank_d   = blank_q;
      case (state_q)
         IDLE: begin
            if (cnt_d != '0) state_d = REQ;
         end
         REQ: begin
            if (cnt_d == '0) begin
               if (GNT_LAT == 0) begin
                  state_d = IDLE;
               end else begin
                  state_d = BLANK;
                  blank_d = BLK_LOAD;
               end
            end
         end
         BLANK: begin
            // grants landing here are the arbiter's pipeline tail: ignore them
            if (blank_q == '0) begin
               state_d = (cnt_d != '0) ? REQ : IDLE;
            end else begin
               blank_d = blank_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         blank_q   <= '0;
         req_q     <= 1'b0;
         ovf_q     <= 1'b0;
         gnt_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         blank_q   <= blank_d;
         req_q     <= (state_d == REQ);
         ovf_q     <= ovf_d;
         gnt_err_q <= gnt_err_d;
      end
   end

   assign req_o     = req_q;
   assign cnt_o     = cnt_q;
   assign full_o    = full;
   assign ovf_o     = ovf_q;
   assign gnt_err_o = gnt_err_q;

`ifdef ARB_REQ_STARVE_MON_EN
   localparam int unsigned SW = $clog2(STARVE_MAX + 1);

   logic [SW-1:0] wait_q, wait_d;
   logic          starve_q, starve_d;

   always_comb begin
      wait_d = '0;
      if ((state_q == REQ) && (state_d == REQ) && !gnt_i) begin
         wait_d = (wait_q == SW'(STARVE_MAX)) ? wait_q : wait_q + 1'b1;
      end
      starve_d = starve_q | (wait_d == SW'(STARVE_MAX));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wait_q   <= '0;
         starve_q <= 1'b0;
      end else begin
         wait_q   <= wait_d;
         starve_q <= starve_d;
      end
   end

   assign starve_o = starve_q;
`else
   assign starve_o = 1'b0;
`endif

endmodule

// File: rtl/arb_req_ctrl.sv
// arb_req_ctrl: upstream request management for the NREQ-way priority
// arbiter. One arb_req_chan per client; this level only packs the buses.
// Optional macro ARB_REQ_STARVE_MON_EN enables per-channel starvation flags.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : per-client request pulses
//   gnt        : onehot0 grant from the arbiter
//   req        : registered request levels to the arbiter
//   pend_cnt   : packed pending counts, channel 0 in the LSBs
//   full       : per-channel count == DEPTH
//   ovf        : sticky per-channel dropped-push flag
//   gnt_err    : sticky per-channel unexpected-grant flag
//   starve     : sticky per-channel starvation flag (0 without the macro)
module arb_req_ctrl
   import arb_pkg::*;
#(
   parameter int unsigned NREQ       = NREQ_DEF,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned GNT_LAT    = 5,
   parameter int unsigned STARVE_MAX = 16,
   localparam int unsigned CNT_W     = cnt_w(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       push,
   input  logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       req,
   output logic [NREQ*CNT_W-1:0] pend_cnt,
   output logic [NREQ-1:0]       full,
   output logic [NREQ-1:0]       ovf,
   output logic [NREQ-1:0]       gnt_err,
   output logic [NREQ-1:0]       starve
);

   if (DEPTH == 0 || STARVE_MAX == 0) begin : g_param_err
      $error("arb_req_ctrl: DEPTH and STARVE_MAX must be non-zero");
   end

   for (genvar i = 0; i < NREQ; i++) begin : g_chan
      arb_req_chan #(
`ifdef ARB_REQ_STARVE_MON_EN
         .STARVE_MAX (STARVE_MAX),
`endif
         .DEPTH      (DEPTH),
         .GNT_LAT    (GNT_LAT),
         .CNT_W      (CNT_W)
      ) u_chan (
         .clk_i      (clk),
         .rst_ni     (rst_n),
         .push_i     (push[i]),
         .gnt_i      (gnt[i]),
         .req_o      (req[i]),
         .cnt_o      (pend_cnt[i*CNT_W +: CNT_W]),
         .full_o     (full[i]),
         .ovf_o      (ovf[i]),
         .gnt_err_o  (gnt_err[i]),
         .starve_o   (starve[i])
      );
   end

endmodule

// File: tb/tb_arb_req_ctrl.sv
module tb_arb_req_ctrl;

   localparam int NREQ       = 3;
   localparam int DEPTH      = 4;
   localparam int GNT_LAT    = 5;
   localparam int STARVE_MAX = 16;
   localparam int CNT_W      = 3;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       push, gnt;
   logic [NREQ-1:0]       req, full, ovf, gnt_err, starve;
   logic [NREQ*CNT_W-1:0] pend_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   arb_req_ctrl #(
      .NREQ       (NREQ),
      .DEPTH      (DEPTH),
      .GNT_LAT    (GNT_LAT),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .gnt      (gnt),
      .req      (req),
      .pend_cnt (pend_cnt),
      .full     (full),
      .ovf      (ovf),
      .gnt_err  (gnt_err),
      .starve   (starve)
   );

   // Reference model: pending count, "asking" flag and remaining blank cycles.
   int m_pend  [NREQ];
   bit m_act   [NREQ];
   int m_blank [NREQ];
   bit m_ovf   [NREQ];
   bit m_err   [NREQ];
   bit m_starve[NREQ];
   int m_wait  [NREQ];

   task automatic model_reset();
      for (int i = 0; i < NREQ; i++) begin
         m_pend[i] = 0; m_act[i] = 0; m_blank[i] = 0;
         m_ovf[i] = 0; m_err[i] = 0; m_starve[i] = 0; m_wait[i] = 0;
      end
   endtask

   task automatic model_step(input logic [NREQ-1:0] p, input logic [NREQ-1:0] g);
      for (int i = 0; i < NREQ; i++) begin
         bit was_req, was_blank, granted, accepted;
         int nxt;
         was_req   = m_act[i];
         was_blank = (m_blank[i] > 0);
         granted   = g[i] && was_req && (m_pend[i] > 0);
         accepted  = p[i] && ((m_pend[i] < DEPTH) || granted);
         if (p[i] && !accepted) m_ovf[i] = 1;
         if (g[i] && ((!was_req && !was_blank) || (was_req && m_pend[i] == 0))) m_err[i] = 1;
         nxt = m_pend[i] + int'(accepted) - int'(granted);
         if (was_req) begin
            if (nxt == 0) begin
               m_act[i]   = 0;
               m_blank[i] = GNT_LAT;
            end
         end else if (was_blank) begin
            m_blank[i]--;
            if (m_blank[i] == 0) m_act[i] = (nxt > 0);
         end else begin
            m_act[i] = (nxt > 0);
         end
`ifdef ARB_REQ_STARVE_MON_EN
         if (was_req && m_act[i] && !g[i])
            m_wait[i] = (m_wait[i] < STARVE_MAX) ? m_wait[i] + 1 : STARVE_MAX;
         else
            m_wait[i] = 0;
         if (m_wait[i] == STARVE_MAX) m_starve[i] = 1;
`endif
         m_pend[i] = nxt;
      end
   endtask

   function automatic logic [NREQ-1:0] exp_req();
      for (int i = 0; i < NREQ; i++) exp_req[i] = m_act[i];
   endfunction
   function automatic logic [NREQ*CNT_W-1:0] exp_pend();
      for (int i = 0; i < NREQ; i++) exp_pend[i*CNT_W +: CNT_W] = CNT_W'(m_pend[i]);
   endfunction
   function automatic logic [NREQ-1:0] exp_full();
      for (int i = 0; i < NREQ; i++) exp_full[i] = (m_pend[i] == DEPTH);
   endfunction
   function automatic logic [NREQ-1:0] exp_ovf();
      for (int i = 0; i < NREQ; i++) exp_ovf[i] = m_ovf[i];
   endfunction
   function automatic logic [NREQ-1:0] exp_err();
      for (int i = 0; i < NREQ; i++) exp_err[i] = m_err[i];
   endfunction
   function automatic logic [NREQ-1:0] exp_starve();
      for (int i = 0; i < NREQ; i++) exp_starve[i] = m_starve[i];
   endfunction

   // Drive one cycle of inputs, advance the model, return at the next negedge.
   task automatic step(input logic [NREQ-1:0] p, input logic [NREQ-1:0] g);
      push = p;
      gnt  = g;
      @(posedge clk);
      model_step(p, g);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      push  = '0;
      gnt   = '0;
      repeat (2) @(negedge clk);
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      push  = 3'b111;
      gnt   = '0;
      repeat (3) @(negedge clk);
      model_reset();
      n_tests++;
      if (req !== 3'b000) begin n_fail++; $display("FAIL reset_req got=%b exp=000", req); end
      n_tests++;
      if (pend_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got=%h exp=0", pend_cnt); end
      n_tests++;
      if ({full, ovf, gnt_err, starve} !== '0)
         begin n_fail++; $display("FAIL reset_flags got=%b exp=0", {full, ovf, gnt_err, starve}); end
      rst_n = 1'b1;
      step(3'b001, 3'b000);
      n_tests++;
      if (req !== 3'b001) begin n_fail++; $display("FAIL first_push_req got=%b exp=001", req); end
      n_tests++;
      if (pend_cnt[CNT_W-1:0] !== 3'd1)
         begin n_fail++; $display("FAIL first_push_cnt got=%0d exp=1", pend_cnt[CNT_W-1:0]); end
   endtask

   task automatic test_single_consume();
      int bad;
      do_reset();
      step(3'b001, 3'b000);
      step(3'b000, 3'b001);
      n_tests++;
      if (req[0] !== 1'b0 || pend_cnt[CNT_W-1:0] !== 3'd0)
         begin n_fail++; $display("FAIL consume_fall got req0=%b cnt=%0d exp req0=0 cnt=0", req[0], pend_cnt[CNT_W-1:0]); end
      bad = 0;
      for (int k = 0; k < GNT_LAT; k++) begin
         step(3'b000, 3'b001);
         if (pend_cnt[CNT_W-1:0] !== 3'd0 || gnt_err[0] !== 1'b0 || req[0] !== 1'b0) bad++;
      end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL blank_grant_ignored got=%0d bad cycles exp=0", bad); end
      // back in IDLE: a new push is visible one cycle later
      step(3'b001, 3'b000);
      n_tests++;
      if (req[0] !== 1'b1) begin n_fail++; $display("FAIL idle_after_blank got=%b exp=1", req[0]); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int k = 0; k < DEPTH; k++) step(3'b010, 3'b000);
      n_tests++;
      if (full[1] !== 1'b1 || ovf[1] !== 1'b0)
         begin n_fail++; $display("FAIL ovf_at_depth got full=%b ovf=%b exp full=1 ovf=0", full[1], ovf[1]); end
      step(3'b010, 3'b000);
      n_tests++;
      if (pend_cnt[CNT_W +: CNT_W] !== 3'd4 || ovf[1] !== 1'b1)
         begin n_fail++; $display("FAIL ovf_drop got cnt=%0d ovf=%b exp cnt=4 ovf=1", pend_cnt[CNT_W +: CNT_W], ovf[1]); end
      step(3'b010, 3'b010);
      n_tests++;
      if (pend_cnt[CNT_W +: CNT_W] !== 3'd4 || full[1] !== 1'b1 || gnt_err[1] !== 1'b0)
         begin n_fail++; $display("FAIL push_and_gnt_full got cnt=%0d full=%b err=%b exp 4 1 0",
                                  pend_cnt[CNT_W +: CNT_W], full[1], gnt_err[1]); end
   endtask

   task automatic test_push_during_blank();
      int early;
      do_reset();
      step(3'b100, 3'b000);
      step(3'b000, 3'b100);
      n_tests++;
      if (req[2] !== 1'b0) begin n_fail++; $display("FAIL blank_entry_req got=%b exp=0", req[2]); end
      early = 0;
      for (int k = 1; k <= GNT_LAT; k++) begin
         step((k == 2) ? 3'b100 : 3'b000, 3'b000);
         if (k < GNT_LAT && req[2] !== 1'b0) early++;
      end
      n_tests++;
      if (early != 0 || req[2] !== 1'b1 || pend_cnt[2*CNT_W +: CNT_W] !== 3'd1)
         begin n_fail++; $display("FAIL blank_push_reassert got early=%0d req=%b cnt=%0d exp 0 1 1",
                                  early, req[2], pend_cnt[2*CNT_W +: CNT_W]); end
   endtask

   task automatic test_spurious_grant();
      do_reset();
      step(3'b000, 3'b010);
      n_tests++;
      if (gnt_err !== 3'b010 || pend_cnt !== '0)
         begin n_fail++; $display("FAIL spurious_grant got err=%b cnt=%h exp err=010 cnt=0", gnt_err, pend_cnt); end
   endtask

   task automatic test_starve();
      logic [NREQ-1:0] exp_final;
`ifdef ARB_REQ_STARVE_MON_EN
      exp_final = 3'b100;
`else
      exp_final = 3'b000;
`endif
      do_reset();
      step(3'b101, 3'b000);
      for (int k = 0; k < STARVE_MAX - 1; k++) step(3'b001, 3'b001);
      n_tests++;
      if (starve !== 3'b000) begin n_fail++; $display("FAIL starve_early got=%b exp=000", starve); end
      step(3'b001, 3'b001);
      n_tests++;
      if (starve !== exp_final) begin n_fail++; $display("FAIL starve_set got=%b exp=%b", starve, exp_final); end
   endtask

   task automatic test_random();
      logic [NREQ-1:0] p, g;
      int bad;
      do_reset();
      bad = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         p = NREQ'($urandom & $urandom);
         g = NREQ'(1 << $urandom_range(0, NREQ - 1));
         case ($urandom_range(0, 3))
            0:       g = '0;
            1:       ;                 // unfiltered grant, may hit IDLE
            default: g = g & req;
         endcase
         step(p, g);
         n_tests++;
         if (req !== exp_req() || pend_cnt !== exp_pend() || full !== exp_full() ||
             ovf !== exp_ovf() || gnt_err !== exp_err() || starve !== exp_starve()) begin
            n_fail++;
            if (bad++ < 10)
               $display("FAIL random cyc=%0d got req=%b cnt=%h full=%b ovf=%b err=%b stv=%b exp req=%b cnt=%h full=%b ovf=%b err=%b stv=%b",
                        cyc, req, pend_cnt, full, ovf, gnt_err, starve,
                        exp_req(), exp_pend(), exp_full(), exp_ovf(), exp_err(), exp_starve());
         end
      end
   endtask

   task automatic test_reset_midop();
      do_reset();
      step(3'b111, 3'b000);
      step(3'b111, 3'b000);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_tests++;
      if (req !== 3'b000 || pend_cnt !== '0)
         begin n_fail++; $display("FAIL async_reset got req=%b cnt=%h exp 000 0", req, pend_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      push  = '0;
      gnt   = '0;
      @(negedge clk);
      test_reset();
      test_single_consume();
      test_overflow();
      test_push_during_blank();
      test_spurious_grant();
      test_starve();
      test_random();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
